// File: rtl/pulse_sync_rx_multi.sv
// pulse_sync_rx_multi
//
// Multi-channel receiver for toggle-encoded events that cross from a foreign
// clock domain. Each channel synchronizes its toggle line and detects level
// changes. Detected events are queued in a small saturating pending counter,
// and the channel acknowledges each stored event back to its source by
// flipping ack_tgl.
//
// Ports
//   clk        : sole clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   tgl_in     : [CH] toggle-encoded events; each level change is one event
//   evt_ready  : [CH] consumer takes one pending event this cycle
//   ovf_clr    : [CH] single-cycle clear of the sticky overflow flag
//   evt_pulse  : [CH] one-cycle pulse per detected event
//   evt_valid  : [CH] channel holds at least one pending event
//   ack_tgl    : [CH] flips once per stored event (not for dropped events)
//   ovf        : [CH] sticky flag, set when an event was dropped on a full counter
//   busy       : some channel has an event in flight or pending
module pulse_sync_rx_multi #(
  parameter int CH          = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] tgl_in,
  input  logic [CH-1:0] evt_ready,
  input  logic [CH-1:0] ovf_clr,
  output logic [CH-1:0] evt_pulse,
  output logic [CH-1:0] evt_valid,
  output logic [CH-1:0] ack_tgl,
  output logic [CH-1:0] ovf,
  output logic          busy
);

  generate
    if (CH < 1 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_param
      $error("pulse_sync_rx_multi: illegal parameters (need CH>=1, SYNC_STAGES>=2, CNT_W>=1)");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0][SYNC_STAGES-1:0] sync_p0;
  logic [CH-1:0]                  edge_ref_p1;
  logic [CH-1:0][CNT_W-1:0]       cnt_p2;

  logic [CH-1:0] evt_edge;
  logic [CH-1:0] accept;
  logic [CH-1:0] stored;
  logic [CH-1:0] dropped;

  // The counter saturates at CNT_MAX and never goes below zero. An event that
  // arrives together with an accept replaces the one consumed, so the count
  // holds.
  function automatic logic [CNT_W-1:0] sat_cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             evt,
    input logic             acc
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (evt && !acc && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_W'(1);
    end else if (!evt && acc) begin
      nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    evt_edge  = '0;
    accept    = '0;
    stored    = '0;
    dropped   = '0;
    evt_valid = '0;
    for (int i = 0; i < CH; i++) begin
      evt_valid[i] = (cnt_p2[i] != '0);
      evt_edge[i]  = sync_p0[i][SYNC_STAGES-1] ^ edge_ref_p1[i];
      // evt_ready is ignored while nothing is pending.
      accept[i]    = evt_valid[i] & evt_ready[i];
      stored[i]    = evt_edge[i] & (accept[i] | (cnt_p2[i] != CNT_MAX));
      dropped[i]   = evt_edge[i] & ~accept[i] & (cnt_p2[i] == CNT_MAX);
    end
  end

  // Busy also covers events still travelling through the synchronizer. Any
  // sync stage that differs from the edge reference is an in-flight event.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if ((cnt_p2[i] != '0) ||
          ((sync_p0[i] ^ {SYNC_STAGES{edge_ref_p1[i]}}) != '0)) begin
        busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0     <= '0;
      edge_ref_p1 <= '0;
      cnt_p2      <= '0;
      evt_pulse   <= '0;
      ack_tgl     <= '0;
      ovf         <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        // p0: synchronizer chain
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], tgl_in[i]};
        // p1: edge reference
        edge_ref_p1[i] <= sync_p0[i][SYNC_STAGES-1];
        // p2: event pulse, pending count, acknowledge, overflow
        evt_pulse[i] <= evt_edge[i];
        cnt_p2[i]    <= sat_cnt_next(cnt_p2[i], evt_edge[i], accept[i]);
        if (stored[i]) begin
          ack_tgl[i] <= ~ack_tgl[i];
        end
        // An overflow in the same cycle as a clear keeps the flag set.
        if (dropped[i]) begin
          ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          ovf[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
module tb_pulse_sync_rx_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tgl_in;
  logic [2:0] evt_ready;
  logic [2:0] ovf_clr;
  logic [2:0] evt_pulse;
  logic [2:0] evt_valid;
  logic [2:0] ack_tgl;
  logic [2:0] ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_sync_rx_multi #(
    .CH(3),
    .SYNC_STAGES(2),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tgl_in(tgl_in),
    .evt_ready(evt_ready),
    .ovf_clr(ovf_clr),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .ack_tgl(ack_tgl),
    .ovf(ovf),
    .busy(busy)
  );

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; tgl_in = '0; evt_ready = '0; ovf_clr = '0;
    cyc(3);
    checks++;
    if ({evt_pulse, evt_valid, ack_tgl, ovf, busy} !== 13'b0) begin
      errors++;
      $display("FAIL reset_hold outputs=%b required=0", {evt_pulse, evt_valid, ack_tgl, ovf, busy});
    end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      checks++;
      if ({evt_pulse, evt_valid, ack_tgl, ovf, busy} !== 13'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d outputs=%b required=0", c, {evt_pulse, evt_valid, ack_tgl, ovf, busy});
      end
    end
  endtask

  task automatic test_single_event;
    tgl_in[0] = 1'b1;
    cyc(1);
    checks++;
    if (evt_pulse !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_edge1 pulse=%b busy=%b required pulse=000 busy=1", evt_pulse, busy);
    end
    cyc(1);
    checks++;
    if (evt_pulse !== 3'b000) begin
      errors++;
      $display("FAIL single_edge2 pulse=%b required=000", evt_pulse);
    end
    cyc(1);
    checks++;
    if (evt_pulse !== 3'b001 || evt_valid !== 3'b001 || ack_tgl !== 3'b001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_edge3 pulse=%b valid=%b ack=%b busy=%b required 001 001 001 1",
               evt_pulse, evt_valid, ack_tgl, busy);
    end
    cyc(1);
    checks++;
    if (evt_pulse !== 3'b000 || evt_valid !== 3'b001) begin
      errors++;
      $display("FAIL single_after pulse=%b valid=%b required pulse=000 valid=001", evt_pulse, evt_valid);
    end
    evt_ready[0] = 1'b1;
    cyc(1);
    evt_ready[0] = 1'b0;
    checks++;
    if (evt_valid !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_consume valid=%b busy=%b required valid=000 busy=0", evt_valid, busy);
    end
  endtask

  task automatic test_overflow;
    logic [3:0] exp_ack = 4'b1101;
    logic [3:0] exp_ovf = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tgl_in[1] = ~tgl_in[1];
      cyc(3);
      checks++;
      if (evt_pulse[1] !== 1'b1 || ack_tgl[1] !== exp_ack[k] || ovf[1] !== exp_ovf[k] || evt_valid[1] !== 1'b1) begin
        errors++;
        $display("FAIL ovf_toggle%0d pulse=%b ack=%b ovf=%b valid=%b required 1 %b %b 1",
                 k, evt_pulse[1], ack_tgl[1], ovf[1], evt_valid[1], exp_ack[k], exp_ovf[k]);
      end
      cyc(2);
    end
    ovf_clr[1] = 1'b1;
    cyc(1);
    ovf_clr[1] = 1'b0;
    checks++;
    if (ovf[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b required=0", ovf[1]);
    end
    // Drain: a saturated count of 3 needs exactly three accepts.
    evt_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      checks++;
      if (evt_valid[1] !== (k < 2)) begin
        errors++;
        $display("FAIL ovf_drain%0d valid=%b required=%b", k, evt_valid[1], (k < 2));
      end
    end
    cyc(2);
    evt_ready[1] = 1'b0;
    checks++;
    if (evt_valid !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_underflow valid=%b busy=%b required valid=000 busy=0", evt_valid, busy);
    end
  endtask

  task automatic test_accept_collide;
    tgl_in[2] = 1'b1;
    cyc(4);
    checks++;
    if (evt_valid[2] !== 1'b1 || ack_tgl[2] !== 1'b1) begin
      errors++;
      $display("FAIL collide_setup valid=%b ack=%b required 1 1", evt_valid[2], ack_tgl[2]);
    end
    tgl_in[2] = 1'b0;
    cyc(2);
    evt_ready[2] = 1'b1;
    cyc(1);
    evt_ready[2] = 1'b0;
    checks++;
    if (evt_pulse[2] !== 1'b1 || evt_valid[2] !== 1'b1 || ack_tgl[2] !== 1'b0) begin
      errors++;
      $display("FAIL collide_edge pulse=%b valid=%b ack=%b required 1 1 0", evt_pulse[2], evt_valid[2], ack_tgl[2]);
    end
    // The count must still be exactly 1, so one accept empties it.
    evt_ready[2] = 1'b1;
    cyc(1);
    evt_ready[2] = 1'b0;
    checks++;
    if (evt_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL collide_count valid=%b required=0", evt_valid[2]);
    end
  endtask

  task automatic test_simultaneous;
    tgl_in = 3'b100;
    cyc(3);
    checks++;
    if (evt_pulse !== 3'b101 || evt_valid !== 3'b101 || ack_tgl !== 3'b110) begin
      errors++;
      $display("FAIL simul_edge pulse=%b valid=%b ack=%b required 101 101 110", evt_pulse, evt_valid, ack_tgl);
    end
    cyc(1);
    checks++;
    if (evt_pulse !== 3'b000 || evt_valid !== 3'b101) begin
      errors++;
      $display("FAIL simul_after pulse=%b valid=%b required 000 101", evt_pulse, evt_valid);
    end
  endtask

  task automatic test_reset_mid;
    tgl_in = 3'b101;
    cyc(3);
    checks++;
    if (evt_pulse !== 3'b001 || evt_valid !== 3'b101) begin
      errors++;
      $display("FAIL midrst_setup pulse=%b valid=%b required 001 101", evt_pulse, evt_valid);
    end
    tgl_in = 3'b000;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({evt_pulse, evt_valid, ack_tgl, ovf, busy} !== 13'b0) begin
      errors++;
      $display("FAIL midrst_async outputs=%b required=0", {evt_pulse, evt_valid, ack_tgl, ovf, busy});
    end
    cyc(2);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      checks++;
      if (evt_pulse !== 3'b000 || evt_valid !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet cycle %0d pulse=%b valid=%b busy=%b required 000 000 0",
                 c, evt_pulse, evt_valid, busy);
      end
    end
  endtask

  task automatic test_high_at_release;
    int n = 0;
    rst = 1'b0;
    tgl_in = 3'b010;
    cyc(2);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      if (evt_pulse[1] === 1'b1) n++;
    end
    checks++;
    if (n !== 1 || evt_valid !== 3'b010 || ack_tgl !== 3'b010) begin
      errors++;
      $display("FAIL release_high pulses=%0d valid=%b ack=%b required 1 010 010", n, evt_valid, ack_tgl);
    end
  endtask

  task automatic test_ovf_priority;
    // ch1 holds one event; two more fill it, the third overflows under a clear.
    for (int k = 0; k < 2; k++) begin
      tgl_in[1] = ~tgl_in[1];
      cyc(5);
    end
    tgl_in[1] = ~tgl_in[1];
    cyc(2);
    ovf_clr[1] = 1'b1;
    cyc(1);
    ovf_clr[1] = 1'b0;
    checks++;
    if (evt_pulse[1] !== 1'b1 || ovf[1] !== 1'b1 || ack_tgl[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_priority pulse=%b ovf=%b ack=%b required 1 1 1", evt_pulse[1], ovf[1], ack_tgl[1]);
    end
    ovf_clr[1] = 1'b1;
    cyc(1);
    ovf_clr[1] = 1'b0;
    checks++;
    if (ovf[1] !== 1'b0 || evt_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear2 ovf=%b valid=%b required 0 1", ovf[1], evt_valid[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_overflow();
    test_accept_collide();
    test_simultaneous();
    test_reset_mid();
    test_high_at_release();
    test_ovf_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pulse_sync_rx_multi.md
PULSE_SYNC_RX_MULTI -- requirements
Module: pulse_sync_rx_multi

Interface
REQ-001 SHALL have parameter CH, default 3, number of independent event channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter CNT_W, default 2, per-channel pending-event counter width (>=1); CNT_MAX = 2^CNT_W-1.
REQ-004 SHALL fail elaboration if CH<1, SYNC_STAGES<2 or CNT_W<1.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port tgl_in  input  CH  asynchronous toggle-encoded events from a foreign domain; each level change = one event.
REQ-008 SHALL have port evt_ready  input  CH  consumer accepts one pending event per channel per cycle.
REQ-009 SHALL have port ovf_clr  input  CH  per-channel overflow-flag clear, single-cycle.
REQ-010 SHALL have port evt_pulse  output  CH  one-cycle pulse per detected event.
REQ-011 SHALL have port evt_valid  output  CH  channel has >=1 pending event.
REQ-012 SHALL have port ack_tgl  output  CH  toggle returned to source; flips once per event stored.
REQ-013 SHALL have port ovf  output  CH  sticky flag: event dropped on full counter.
REQ-014 SHALL have port busy  output  1  any channel has an event in flight or pending.

Function
REQ-015 Each channel SHALL pass tgl_in[i] through SYNC_STAGES flops, then one edge-reference flop; detected edge = last sync stage XOR edge-reference.
REQ-016 evt_pulse[i] SHALL be registered, high exactly one cycle per detected edge, asserted at rising edge SYNC_STAGES+1, counting edge 1 as the first edge sampling the new tgl_in level.
REQ-017 Pending counter cnt[i] (CNT_W bits) SHALL update on the same edge evt_pulse[i] asserts.
REQ-018 Counter rules, accept = evt_valid[i] & evt_ready[i]: edge & !accept & cnt<CNT_MAX -> cnt+1; edge & !accept & cnt==CNT_MAX -> cnt unchanged, ovf[i] set, event dropped; edge & accept -> cnt unchanged; !edge & accept -> cnt-1; otherwise hold.
REQ-019 evt_valid[i] SHALL equal (cnt[i]!=0), driven from registered count, no combinational path from evt_ready.
REQ-020 evt_ready[i] while evt_valid[i]=0 SHALL be ignored; counter never underflows or wraps.
REQ-021 ack_tgl[i] SHALL flip on the edge the event is stored (REQ-018 increment or edge&accept); it SHALL NOT flip for a dropped event.
REQ-022 ovf[i] SHALL clear on ovf_clr[i]; a same-cycle overflow SHALL win (ovf stays 1).
REQ-023 busy SHALL be OR over channels of (cnt!=0) OR (any sync stage differs from edge-reference), registered-state-derived.
REQ-024 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all be captured in the same cycle.
REQ-025 Toggles faster than one per cycle after synchronization are outside contract; sources SHALL wait for ack_tgl before next toggle.

Reset
REQ-026 rst low SHALL asynchronously clear all sync stages, edge-reference flops, counters, ack_tgl, ovf, evt_pulse; evt_valid=0, busy=0.
REQ-027 Reset mid-operation SHALL discard all pending and in-flight events, no partial pulse after release.
REQ-028 If tgl_in[i]=1 at reset release, exactly one event SHALL be detected on channel i; sources SHALL reset their toggle to 0 in the same reset.

Verification (CH=3, SYNC_STAGES=2, CNT_W=2)
REQ-029 Reset, tgl_in=0 -> all outputs 0, busy=0, stable for 10 cycles.
REQ-030 tgl_in[0] 0->1, evt_ready=0 -> evt_pulse[0]=1 one cycle at edge 3, evt_valid[0]=1, ack_tgl[0]=1, busy=1; then evt_ready[0]=1 one cycle -> evt_valid[0]=0 next cycle, busy=0.
REQ-031 Four toggles on ch1 spaced 5 cycles, evt_ready=0 -> cnt saturates at 3, ovf[1]=1 after 4th, ack_tgl[1] flips 3 times (ends 1); ovf_clr[1] -> ovf[1]=0.
REQ-032 cnt[2]=1, new edge coincides with evt_ready[2]=1 -> cnt stays 1, evt_valid[2]=1, ack_tgl[2] flips.
REQ-033 tgl_in[0] and tgl_in[2] toggle same cycle -> evt_pulse=3'b101 in one cycle, both counters 1, ch1 untouched.
REQ-034 cnt[0]=2, rst pulsed low mid-cycle -> outputs 0 immediately; after release with tgl_in=0, no evt_pulse for 10 cycles.
